// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, combinational imem fetch and IF/ID pipeline register.
// Optional performance counters are enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        misalign_err
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic        misalign_q, misalign_d;
  logic        bubble, capture;

  // A redirect outranks stall for the PC; flush or redirect outranks stall for IF/ID.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    bubble        = flush | redirect;
    capture       = ~bubble & ~stall;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
    if (bubble) begin
      id_valid_d = 1'b0;
      id_instr_d = 32'h0;
    end else if (capture) begin
      id_instr_d    = imem_rdata;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_valid_d    = 1'b1;
    end
    misalign_d = misalign_q | (redirect & (|redirect_pc[1:0]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= 32'h0;
      id_pc_q       <= 32'h0;
      id_pc_plus4_q <= 32'h0;
      id_valid_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_addr    = pc_q;
  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus4  = id_pc_plus4_q;
  assign id_valid     = id_valid_q;
  assign misalign_err = misalign_q;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'b0, capture};
    bubble_cnt_d = bubble_cnt_q + {31'b0, bubble};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; instance u_dut uses RESET_PC = 0,
// u_wrap uses RESET_PC = 32'hFFFF_FFFC to exercise the reset-time PC wrap.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr, imem_rdata;
   logic        stall, flush, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] id_instr, id_pc, id_pc_plus4;
   logic        id_valid, misalign_err;

   logic [31:0] w_imem_addr, w_imem_rdata;
   logic [31:0] w_id_instr, w_id_pc, w_id_pc_plus4;
   logic        w_id_valid, w_misalign_err;
   logic        w_zero;
   logic [31:0] w_zero32;

`ifdef IF_STAGE_PERF_CNT_EN
   logic [31:0] fetch_count, bubble_count;
   logic [31:0] w_fetch_count, w_bubble_count;
`endif

   int vecCount = 0;
   int errCount = 0;

   // Instruction memory model: word k holds the value k.
   assign imem_rdata   = imem_addr >> 2;
   assign w_imem_rdata = w_imem_addr >> 2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
      .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
      .id_valid(id_valid), .misalign_err(misalign_err)
`ifdef IF_STAGE_PERF_CNT_EN
      , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
      .stall(w_zero), .flush(w_zero), .redirect(w_zero), .redirect_pc(w_zero32),
      .id_instr(w_id_instr), .id_pc(w_id_pc), .id_pc_plus4(w_id_pc_plus4),
      .id_valid(w_id_valid), .misalign_err(w_misalign_err)
`ifdef IF_STAGE_PERF_CNT_EN
      , .fetch_count(w_fetch_count), .bubble_count(w_bubble_count)
`endif
   );

   // Single comparison point: counts every vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of control inputs, then samples 1 time unit after the rising edge.
   task automatic applyStimulus(input logic s, input logic f, input logic r, input logic [31:0] rpc);
      stall       = s;
      flush       = f;
      redirect    = r;
      redirect_pc = rpc;
      @(posedge clk);
      #1;
      stall    = 1'b0;
      flush    = 1'b0;
      redirect = 1'b0;
   endtask

   task automatic checkIfId(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] pc, input logic valid);
      checkOutput({tag, ".addr"}, imem_addr, addr);
      checkOutput({tag, ".instr"}, id_instr, instr);
      checkOutput({tag, ".pc"}, id_pc, pc);
      checkOutput({tag, ".valid"}, {31'b0, id_valid}, {31'b0, valid});
   endtask

   initial begin
      w_zero      = 1'b0;
      w_zero32    = 32'h0;
      stall       = 1'b0;
      flush       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      rst         = 1'b1;
      #1;
      checkIfId("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      checkOutput("reset.plus4", id_pc_plus4, 32'h0);
      checkOutput("reset.misalign", {31'b0, misalign_err}, 32'h0);
      checkOutput("reset.wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("post_reset.addr", imem_addr, 32'h0);

      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("c1", 32'h4, 32'h0, 32'h0, 1'b1);
      checkOutput("c1.plus4", id_pc_plus4, 32'h4);
      checkOutput("wrap.addr", w_imem_addr, 32'h0);
      checkOutput("wrap.id_pc", w_id_pc, 32'hFFFF_FFFC);
      checkOutput("wrap.plus4", w_id_pc_plus4, 32'h0);
      checkOutput("wrap.instr", w_id_instr, 32'h3FFF_FFFF);

      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("c2", 32'h8, 32'h1, 32'h4, 1'b1);

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("stall1", 32'h8, 32'h1, 32'h4, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("stall2", 32'h8, 32'h1, 32'h4, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("resume", 32'hC, 32'h2, 32'h8, 1'b1);
      checkOutput("resume.plus4", id_pc_plus4, 32'hC);

      applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
      checkIfId("redir_stall", 32'h40, 32'h0, 32'h8, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("redir_next", 32'h44, 32'h10, 32'h40, 1'b1);
      checkOutput("redir_next.plus4", id_pc_plus4, 32'h44);

      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkIfId("flush", 32'h48, 32'h0, 32'h40, 1'b0);
      checkOutput("flush.plus4", id_pc_plus4, 32'h44);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkIfId("flush_stall", 32'h48, 32'h0, 32'h40, 1'b0);
      checkOutput("pre_misalign", {31'b0, misalign_err}, 32'h0);

      applyStimulus(1'b0, 1'b0, 1'b1, 32'h42);
      checkIfId("misalign", 32'h40, 32'h0, 32'h40, 1'b0);
      checkOutput("misalign.flag", {31'b0, misalign_err}, 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("misalign_next", 32'h44, 32'h10, 32'h40, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("misalign.sticky", {31'b0, misalign_err}, 32'h1);

      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("top.addr", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("wrap_run", 32'h0, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 1'b1);
      checkOutput("wrap_run.plus4", id_pc_plus4, 32'h0);

      // Asynchronous reset mid-stall and mid-redirect must discard the pending action.
      @(negedge clk);
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      rst         = 1'b1;
      #1;
      checkIfId("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
      checkOutput("async_rst.misalign", {31'b0, misalign_err}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("rst_hold.addr", imem_addr, 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
      checkOutput("rst.fetch_count", fetch_count, 32'h0);
      checkOutput("rst.bubble_count", bubble_count, 32'h0);
`endif
      @(negedge clk);
      stall    = 1'b0;
      redirect = 1'b0;
      rst      = 1'b0;

      // Ten cycles with stalls at 2 and 3 and one flush at 5: 7 captures, 1 bubble.
      for (int i = 0; i < 10; i++) begin
         applyStimulus((i == 2) || (i == 3), (i == 5), 1'b0, 32'h0);
         if (i == 0) checkIfId("rerelease", 32'h4, 32'h0, 32'h0, 1'b1);
      end
      checkIfId("window_end", 32'h20, 32'h7, 32'h1C, 1'b1);
`ifdef IF_STAGE_PERF_CNT_EN
      checkOutput("fetch_count", fetch_count, 32'd7);
      checkOutput("bubble_count", bubble_count, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
